// File: rtl/jtvigil_romarb.sv
// Three-channel ROM fetch arbiter with a one-word cache per channel, sharing one SDRAM port.
// Optional macro JTVIGIL_ROMARB_RR_EN selects round-robin instead of fixed obj > scr2 > scr1 priority.
module jtvigil_romarb #(
    parameter logic [21:0] SCR1_OFFSET = 22'h00000,
    parameter logic [21:0] SCR2_OFFSET = 22'h10000,
    parameter logic [21:0] OBJ_OFFSET  = 22'h30000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        scr1_cs,
    input  logic [16:0] scr1_addr,
    output logic        scr1_ok,
    output logic [31:0] scr1_data,
    input  logic        scr2_cs,
    input  logic [17:0] scr2_addr,
    output logic        scr2_ok,
    output logic [31:0] scr2_data,
    input  logic        obj_cs,
    input  logic [17:0] obj_addr,
    output logic        obj_ok,
    output logic [31:0] obj_data,
    output logic        sdram_req,
    output logic [21:0] sdram_addr,
    input  logic        sdram_ack,
    input  logic        sdram_dok,
    input  logic [31:0] sdram_din
);
    // Handshake: sdram_req stays high with a stable sdram_addr until a one-cycle
    // sdram_ack; the word then arrives on the one-cycle sdram_dok (may coincide with ack).
    typedef enum logic [1:0] {IDLE, REQ, DATA} state_t;

    localparam logic [1:0] CH_SCR1 = 2'd0;
    localparam logic [1:0] CH_SCR2 = 2'd1;
    localparam logic [1:0] CH_OBJ  = 2'd2;

    state_t      state_q;
    logic [1:0]  sel_q;
    logic [17:0] addr_q;
    logic        req_q;
    logic [21:0] req_addr_q;

    logic        v1_q, v2_q, vo_q;
    logic [16:0] tag1_q;
    logic [17:0] tag2_q, tago_q;
    logic [31:0] d1_q, d2_q, do_q;

    logic        hit1, hit2, hito;
    logic [2:0]  pend;
    logic [1:0]  sel_d;
    logic [17:0] addr_d;
    logic [21:0] off_d;
    logic [21:0] req_addr_d;
    logic        fill;

    assign hit1 = v1_q & (tag1_q == scr1_addr);
    assign hit2 = v2_q & (tag2_q == scr2_addr);
    assign hito = vo_q & (tago_q == obj_addr);

    assign scr1_ok   = scr1_cs & hit1;
    assign scr2_ok   = scr2_cs & hit2;
    assign obj_ok    = obj_cs  & hito;
    assign scr1_data = d1_q;
    assign scr2_data = d2_q;
    assign obj_data  = do_q;
    assign sdram_req  = req_q;
    assign sdram_addr = req_addr_q;

    assign pend = {obj_cs & ~hito, scr2_cs & ~hit2, scr1_cs & ~hit1};

`ifdef JTVIGIL_ROMARB_RR_EN
    logic [1:0] last_q;
    logic       found;

    // Search starts just after the channel served last, wrapping scr1 -> scr2 -> obj.
    always_comb begin
        sel_d = CH_SCR1;
        found = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            if (!found && pend[(int'(last_q) + k) % 3]) begin
                sel_d = 2'((int'(last_q) + k) % 3);
                found = 1'b1;
            end
        end
    end
`else
    always_comb begin
        if (pend[2])      sel_d = CH_OBJ;
        else if (pend[1]) sel_d = CH_SCR2;
        else              sel_d = CH_SCR1;
    end
`endif

    always_comb begin
        case (sel_d)
            CH_SCR1: begin addr_d = {1'b0, scr1_addr}; off_d = SCR1_OFFSET; end
            CH_SCR2: begin addr_d = scr2_addr;         off_d = SCR2_OFFSET; end
            default: begin addr_d = obj_addr;          off_d = OBJ_OFFSET;  end
        endcase
        req_addr_d = off_d + {4'b0000, addr_d};
    end

    assign fill = ((state_q == REQ) & sdram_ack & sdram_dok) |
                  ((state_q == DATA) & sdram_dok);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sel_q      <= CH_SCR1;
            addr_q     <= '0;
            req_q      <= 1'b0;
            req_addr_q <= '0;
            v1_q <= 1'b0; v2_q <= 1'b0; vo_q <= 1'b0;
            tag1_q <= '0; tag2_q <= '0; tago_q <= '0;
            d1_q <= '0;   d2_q <= '0;   do_q <= '0;
`ifdef JTVIGIL_ROMARB_RR_EN
            last_q <= CH_OBJ;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (|pend) begin
                        sel_q      <= sel_d;
                        addr_q     <= addr_d;
                        req_addr_q <= req_addr_d;
                        req_q      <= 1'b1;
                        state_q    <= REQ;
`ifdef JTVIGIL_ROMARB_RR_EN
                        last_q     <= sel_d;
`endif
                    end
                end
                REQ: begin
                    if (sdram_ack) begin
                        req_q   <= 1'b0;
                        state_q <= sdram_dok ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (sdram_dok) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase

            // Only the latched channel is refilled, with the latched address as its tag.
            if (fill) begin
                case (sel_q)
                    CH_SCR1: begin v1_q <= 1'b1; tag1_q <= addr_q[16:0]; d1_q <= sdram_din; end
                    CH_SCR2: begin v2_q <= 1'b1; tag2_q <= addr_q;       d2_q <= sdram_din; end
                    default: begin vo_q <= 1'b1; tago_q <= addr_q;       do_q <= sdram_din; end
                endcase
            end
        end
    end
endmodule
